// File: rtl/opll_bus_writer.sv
// opll_bus_writer: FIFO-buffered initiator for the YM2413 OPLL register-write bus (A0/D/WR).
// Optional define OPLL_WRITER_ADDR_SKIP_EN skips the address phase when the address repeats.
`default_nettype none

module opll_bus_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int STROBE_LEN = 2,
  parameter int ADDR_WAIT  = 12,
  parameter int DATA_WAIT  = 84
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [7:0]                         in_addr,
  input  logic [7:0]                         in_data,
  output logic [7:0]                         bus_d,
  output logic                               bus_a0,
  output logic                               bus_wr,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = $clog2(FIFO_DEPTH + 1);
  localparam int MAX_SW  = (STROBE_LEN > ADDR_WAIT) ? STROBE_LEN : ADDR_WAIT;
  localparam int CNT_MAX = (MAX_SW > DATA_WAIT) ? MAX_SW : DATA_WAIT;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  // Counter reload values are length-1 so that a timed state lasts exactly its length.
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_LEN - 1);
  localparam logic [CNT_W-1:0] AWAIT_LOAD  = CNT_W'(ADDR_WAIT - 1);
  localparam logic [CNT_W-1:0] DWAIT_LOAD  = CNT_W'(DATA_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_ADDR_SETUP  = 3'd1,
    S_ADDR_STROBE = 3'd2,
    S_ADDR_WAIT   = 3'd3,
    S_DATA_SETUP  = 3'd4,
    S_DATA_STROBE = 3'd5,
    S_DATA_WAIT   = 3'd6
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       data_q;

  logic [15:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic             push;
  logic             pop;
  logic [7:0]       head_addr;
  logic [7:0]       head_data;

  assign in_ready   = (level != LVL_W'(FIFO_DEPTH));
  assign push       = in_valid && in_ready;
  // Pop depends only on registered level, so a fresh entry waits one edge (no bypass).
  assign pop        = (state == S_IDLE) && (level != '0);
  assign head_addr  = mem[rd_ptr][15:8];
  assign head_data  = mem[rd_ptr][7:0];
  assign fifo_level = level;
  assign busy       = (state != S_IDLE) || (level != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_addr, in_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

`ifdef OPLL_WRITER_ADDR_SKIP_EN
  logic [7:0] addr_q;
  logic [7:0] cache_addr;
  logic       cache_valid;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      data_q      <= '0;
      bus_d       <= '0;
      bus_a0      <= 1'b0;
      bus_wr      <= 1'b0;
`ifdef OPLL_WRITER_ADDR_SKIP_EN
      addr_q      <= '0;
      cache_addr  <= '0;
      cache_valid <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          bus_wr <= 1'b0;
          if (pop) begin
            data_q <= head_data;
`ifdef OPLL_WRITER_ADDR_SKIP_EN
            addr_q <= head_addr;
            if (cache_valid && (cache_addr == head_addr)) begin
              state  <= S_DATA_SETUP;
              bus_d  <= head_data;
              bus_a0 <= 1'b1;
            end else begin
              state  <= S_ADDR_SETUP;
              bus_d  <= head_addr;
              bus_a0 <= 1'b0;
            end
`else
            state  <= S_ADDR_SETUP;
            bus_d  <= head_addr;
            bus_a0 <= 1'b0;
`endif
          end
        end

        S_ADDR_SETUP: begin
          state  <= S_ADDR_STROBE;
          bus_wr <= 1'b1;
          cnt    <= STROBE_LOAD;
`ifdef OPLL_WRITER_ADDR_SKIP_EN
          cache_addr  <= addr_q;
          cache_valid <= 1'b1;
`endif
        end

        S_ADDR_STROBE: begin
          if (cnt == '0) begin
            state  <= S_ADDR_WAIT;
            bus_wr <= 1'b0;
            cnt    <= AWAIT_LOAD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        S_ADDR_WAIT: begin
          if (cnt == '0) begin
            state  <= S_DATA_SETUP;
            bus_d  <= data_q;
            bus_a0 <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        S_DATA_SETUP: begin
          state  <= S_DATA_STROBE;
          bus_wr <= 1'b1;
          cnt    <= STROBE_LOAD;
        end

        S_DATA_STROBE: begin
          if (cnt == '0) begin
            state  <= S_DATA_WAIT;
            bus_wr <= 1'b0;
            cnt    <= DWAIT_LOAD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        S_DATA_WAIT: begin
          if (cnt == '0) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        default: begin
          state  <= S_IDLE;
          bus_wr <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_opll_bus_writer.sv
// tb_opll_bus_writer: directed checks of opll_bus_writer at default timing plus a short-timing instance.
`default_nettype none

module tb_opll_bus_writer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_addr = 8'h00;
  logic [7:0] in_data = 8'h00;
  logic [7:0] bus_d;
  logic       bus_a0;
  logic       bus_wr;
  logic       busy;
  logic [2:0] fifo_level;

  logic       in_valid2 = 1'b0;
  logic       in_ready2;
  logic [7:0] in_addr2 = 8'h00;
  logic [7:0] in_data2 = 8'h00;
  logic [7:0] bus_d2;
  logic       bus_a02;
  logic       bus_wr2;
  logic       busy2;
  logic [2:0] fifo_level2;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  opll_bus_writer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .bus_d(bus_d), .bus_a0(bus_a0),
    .bus_wr(bus_wr), .busy(busy), .fifo_level(fifo_level)
  );

  opll_bus_writer #(.FIFO_DEPTH(4), .STROBE_LEN(1), .ADDR_WAIT(3), .DATA_WAIT(5)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_addr(in_addr2), .in_data(in_data2), .bus_d(bus_d2), .bus_a0(bus_a02),
    .bus_wr(bus_wr2), .busy(busy2), .fifo_level(fifo_level2)
  );

  // Strobe log: rise time, {a0,d} at rise, pulse widths, and hold violations.
  int         rise_t[$];
  logic [8:0] rise_v[$];
  int         widths[$];
  int         unstable = 0;
  int         wc = 0;
  logic       pw = 1'b0;
  logic [7:0] pd = 8'h00;
  logic       pa = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      pw <= 1'b0;
      wc <= 0;
    end else begin
      if (bus_wr && !pw) begin
        rise_t.push_back(cyc);
        rise_v.push_back({bus_a0, bus_d});
      end
      if (pw && (bus_d !== pd || bus_a0 !== pa)) unstable <= unstable + 1;
      if (bus_wr) wc <= pw ? wc + 1 : 1;
      else if (pw) widths.push_back(wc);
      pw <= bus_wr;
      pd <= bus_d;
      pa <= bus_a0;
    end
  end

  int         rise2_t[$];
  logic [8:0] rise2_v[$];
  int         widths2[$];
  int         wc2 = 0;
  logic       pw2 = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      pw2 <= 1'b0;
      wc2 <= 0;
    end else begin
      if (bus_wr2 && !pw2) begin
        rise2_t.push_back(cyc);
        rise2_v.push_back({bus_a02, bus_d2});
      end
      if (bus_wr2) wc2 <= pw2 ? wc2 + 1 : 1;
      else if (pw2) widths2.push_back(wc2);
      pw2 <= bus_wr2;
    end
  end

  task automatic clear_logs;
    rise_t.delete(); rise_v.delete(); widths.delete();
    rise2_t.delete(); rise2_v.delete(); widths2.delete();
  endtask

  task automatic push1(input logic [7:0] a, input logic [7:0] d, output int t);
    int n;
    n = 0;
    @(negedge clk);
    in_addr = a; in_data = d; in_valid = 1'b1;
    while (!in_ready && n < 300) begin @(negedge clk); n++; end
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL push_ready: in_ready=%b after %0d cycles, want 1", in_ready, n);
    end
    t = cyc + 1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic push2(input logic [7:0] a, input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    in_addr2 = a; in_data2 = d; in_valid2 = 1'b1;
    while (!in_ready2 && n < 300) begin @(negedge clk); n++; end
    total++;
    if (in_ready2 !== 1'b1) begin
      bad++; $display("FAIL push2_ready: in_ready=%b after %0d cycles, want 1", in_ready2, n);
    end
    @(negedge clk);
    in_valid2 = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < limit) begin @(negedge clk); n++; end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL idle_timeout: busy=%b after %0d cycles, want 0", busy, n); end
  endtask

  task automatic do_reset;
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    clear_logs();
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++;
    if ({bus_wr, bus_a0, bus_d} !== 10'd0 || busy !== 1'b0 || fifo_level !== 3'd0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_hold: wr=%b a0=%b d=%h busy=%b level=%0d ready=%b, want 0 0 00 0 0 1",
                      bus_wr, bus_a0, bus_d, busy, fifo_level, in_ready);
    end
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus_wr, bus_a0, bus_d} !== 10'd0 || busy !== 1'b0 || fifo_level !== 3'd0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_idle: wr=%b a0=%b d=%h busy=%b level=%0d ready=%b, want 0 0 00 0 0 1",
                      bus_wr, bus_a0, bus_d, busy, fifo_level, in_ready);
    end
    total++;
    if (bus_wr2 !== 1'b0 || busy2 !== 1'b0 || fifo_level2 !== 3'd0 || in_ready2 !== 1'b1) begin
      bad++; $display("FAIL reset_dut2: wr=%b busy=%b level=%0d ready=%b, want 0 0 0 1",
                      bus_wr2, busy2, fifo_level2, in_ready2);
    end
    clear_logs();
  endtask

  task automatic test_single;
    int t, errs, firstk, u0;
    logic ew, ea, eb;
    logic [7:0] ed;
    errs = 0; firstk = -1; u0 = unstable;
    push1(8'h10, 8'h5A, t);
    total++;
    if (busy !== 1'b1 || fifo_level !== 3'd1) begin
      bad++; $display("FAIL single_queued: busy=%b level=%0d, want 1 1", busy, fifo_level);
    end
    // Offset k counts samples after the accept edge: setup at 1, strobes 2-3, data setup 16, strobes 17-18.
    for (int k = 1; k <= 103; k++) begin
      @(negedge clk);
      ew = (k == 2 || k == 3 || k == 17 || k == 18);
      ea = (k >= 16);
      ed = (k >= 16) ? 8'h5A : 8'h10;
      eb = (k < 103);
      if (bus_wr !== ew || bus_a0 !== ea || bus_d !== ed || busy !== eb) begin
        errs++;
        if (firstk < 0) firstk = k;
      end
    end
    total++;
    if (errs !== 0) begin
      bad++; $display("FAIL single_wave: %0d wrong samples (first at offset %0d), want 0", errs, firstk);
    end
    total++;
    if (widths.size() !== 2 || widths[0] !== 2 || widths[1] !== 2) begin
      bad++; $display("FAIL single_widths: count=%0d first=%0d, want 2 pulses of 2", widths.size(),
                      (widths.size() > 0) ? widths[0] : -1);
    end
    total++;
    if (unstable !== u0) begin
      bad++; $display("FAIL single_hold: %0d changes while strobing, want 0", unstable - u0);
    end
    clear_logs();
  endtask

  task automatic test_order;
    int t;
    logic [8:0] ev[4];
    int errs;
    ev = '{9'h030, 9'h111, 9'h020, 9'h122};
    errs = 0;
    push1(8'h30, 8'h11, t);
    push1(8'h20, 8'h22, t);
    wait_idle(400);
    total++;
    if (rise_v.size() !== 4) begin
      bad++; $display("FAIL order_count: %0d strobes, want 4", rise_v.size());
    end else begin
      for (int i = 0; i < 4; i++) if (rise_v[i] !== ev[i]) errs++;
      total++;
      if (errs !== 0) begin
        bad++; $display("FAIL order_seq: got %h %h %h %h, want 030 111 020 122",
                        rise_v[0], rise_v[1], rise_v[2], rise_v[3]);
      end
      total++;
      if (rise_t[2] - rise_t[0] !== 103) begin
        bad++; $display("FAIL order_spacing: %0d cycles, want 103", rise_t[2] - rise_t[0]);
      end
    end
    clear_logs();
  endtask

  task automatic test_fill;
    int acc[$];
    int idx, peak, lows;
    int exp_off[6];
    exp_off = '{0, 1, 2, 3, 4, 105};
    idx = 0; peak = 0; lows = 0;
    @(negedge clk);
    in_valid = 1'b1; in_addr = 8'h40; in_data = 8'h00;
    for (int k = 0; k < 400 && idx < 6; k++) begin
      if (in_ready) begin acc.push_back(cyc + 1); idx++; end
      else lows++;
      @(negedge clk);
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
      in_addr = 8'h40 + 8'(idx); in_data = 8'(idx);
    end
    in_valid = 1'b0;
    total++;
    if (acc.size() !== 6) begin
      bad++; $display("FAIL fill_accepts: %0d accepted, want 6", acc.size());
    end else begin
      for (int i = 1; i < 6; i++) begin
        total++;
        if (acc[i] - acc[0] !== exp_off[i]) begin
          bad++; $display("FAIL fill_accept_edge: entry %0d at edge %0d, want %0d", i, acc[i] - acc[0], exp_off[i]);
        end
      end
    end
    total++;
    if (peak !== 4 || lows !== 100) begin
      bad++; $display("FAIL fill_level: peak=%0d ready_low_cycles=%0d, want 4 and 100", peak, lows);
    end
    total++;
    if (rise_v.size() < 2 || rise_v[0] !== 9'h040 || rise_v[1] !== 9'h100 || rise_t[1] - rise_t[0] !== 15) begin
      bad++; $display("FAIL fill_first_write: strobes=%0d, want addr 40 then data 00 15 cycles apart", rise_v.size());
    end
  endtask

  task automatic test_reset_mid;
    int t, n;
    do_reset();
    push1(8'h01, 8'hA1, t);
    push1(8'h02, 8'hA2, t);
    push1(8'h03, 8'hA3, t);
    push1(8'h04, 8'hA4, t);
    n = 0;
    while (!(bus_wr && bus_a0) && n < 200) begin @(negedge clk); n++; end
    total++;
    if (!(bus_wr === 1'b1 && bus_a0 === 1'b1 && fifo_level === 3'd3)) begin
      bad++; $display("FAIL reset_mid_reach: wr=%b a0=%b level=%0d, want 1 1 3", bus_wr, bus_a0, fifo_level);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (bus_wr !== 1'b0 || fifo_level !== 3'd0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_mid_async: wr=%b level=%0d busy=%b ready=%b, want 0 0 0 1",
                      bus_wr, fifo_level, busy, in_ready);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    clear_logs();
    push1(8'h55, 8'h66, t);
    @(negedge clk);
    total++;
    if (bus_d !== 8'h55 || bus_a0 !== 1'b0 || bus_wr !== 1'b0) begin
      bad++; $display("FAIL reset_mid_setup: d=%h a0=%b wr=%b, want 55 0 0", bus_d, bus_a0, bus_wr);
    end
    wait_idle(400);
    total++;
    if (rise_v.size() !== 2 || rise_v[0] !== 9'h055 || rise_v[1] !== 9'h166 || rise_t[0] !== t + 2) begin
      bad++; $display("FAIL reset_mid_restart: strobes=%0d first_at=%0d, want 2 strobes addr 55/data 66, first at %0d",
                      rise_v.size(), (rise_t.size() > 0) ? rise_t[0] : -1, t + 2);
    end
    clear_logs();
  endtask

  task automatic test_short_timing;
    int n;
    push2(8'h21, 8'h31);
    push2(8'h22, 8'h32);
    n = 0;
    while (busy2 !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    total++;
    if (busy2 !== 1'b0) begin bad++; $display("FAIL short_idle: busy=%b, want 0", busy2); end
    total++;
    if (rise2_t.size() !== 4) begin
      bad++; $display("FAIL short_count: %0d strobes, want 4", rise2_t.size());
    end else begin
      total++;
      if (rise2_t[1] - rise2_t[0] !== 5 || rise2_t[2] - rise2_t[0] !== 13 || rise2_t[3] - rise2_t[0] !== 18) begin
        bad++; $display("FAIL short_spacing: offsets %0d %0d %0d, want 5 13 18",
                        rise2_t[1] - rise2_t[0], rise2_t[2] - rise2_t[0], rise2_t[3] - rise2_t[0]);
      end
      total++;
      if (rise2_v[0] !== 9'h021 || rise2_v[1] !== 9'h131 || rise2_v[2] !== 9'h022 || rise2_v[3] !== 9'h132) begin
        bad++; $display("FAIL short_seq: got %h %h %h %h, want 021 131 022 132",
                        rise2_v[0], rise2_v[1], rise2_v[2], rise2_v[3]);
      end
    end
    total++;
    if (widths2.size() !== 4 || widths2.sum() !== 4) begin
      bad++; $display("FAIL short_widths: %0d pulses totalling %0d cycles, want 4 pulses of 1",
                      widths2.size(), widths2.sum());
    end
    clear_logs();
  endtask

  task automatic test_addr_skip;
    int t, n_exp, errs, n_addr;
    int et[6];
    logic [8:0] ev[6];
`ifdef OPLL_WRITER_ADDR_SKIP_EN
    n_exp = 5;
    et = '{0, 15, 103, 191, 206, 0};
    ev = '{9'h010, 9'h101, 9'h102, 9'h011, 9'h103, 9'h000};
`else
    n_exp = 6;
    et = '{0, 15, 103, 118, 206, 221};
    ev = '{9'h010, 9'h101, 9'h010, 9'h102, 9'h011, 9'h103};
`endif
    errs = 0; n_addr = 0;
    push1(8'h10, 8'h01, t);
    push1(8'h10, 8'h02, t);
    push1(8'h11, 8'h03, t);
    wait_idle(1000);
    total++;
    if (rise_v.size() !== n_exp) begin
      bad++; $display("FAIL skip_count: %0d strobes, want %0d", rise_v.size(), n_exp);
    end else begin
      for (int i = 0; i < n_exp; i++) begin
        if (rise_v[i] !== ev[i] || rise_t[i] - rise_t[0] !== et[i]) errs++;
        if (rise_v[i][8] == 1'b0) n_addr++;
      end
      total++;
      if (errs !== 0) begin
        bad++; $display("FAIL skip_seq: %0d strobes differ in value or timing, want 0", errs);
      end
      total++;
      if (n_addr !== n_exp - 3) begin
        bad++; $display("FAIL skip_addr_strobes: %0d, want %0d", n_addr, n_exp - 3);
      end
    end
    clear_logs();
    push1(8'h10, 8'h07, t);
    wait_idle(400);
    do_reset();
    push1(8'h10, 8'h04, t);
    wait_idle(400);
    total++;
    if (rise_v.size() !== 2 || rise_v[0] !== 9'h010 || rise_v[1] !== 9'h104) begin
      bad++; $display("FAIL skip_after_reset: strobes=%0d first=%h, want addr 10 then data 04",
                      rise_v.size(), (rise_v.size() > 0) ? rise_v[0] : 9'h1ff);
    end
    clear_logs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_order();
    test_fill();
    test_reset_mid();
    test_short_timing();
    test_addr_skip();
    total++;
    if (unstable !== 0) begin
      bad++; $display("FAIL bus_hold: %0d d/a0 changes while strobing, want 0", unstable);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
